// File: rtl/ex_div_unit.sv
// Iterative restoring divider (signed/unsigned, quotient/remainder) with result tag and divide-by-zero flag.
// Latency: K+3 cycles from accept to out_valid (K = WIDTH/UNROLL), 2 cycles for a zero divisor.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE or DONE with out_ready, never during flush.
module ex_div_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_op_rem,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_zero,
    output logic             busy
);

    localparam int K     = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_POST,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_signed;
    logic               r_op_rem;
    logic [TAG_W-1:0]   r_tag;
    // r_x holds the raw dividend until PREP, then the shifting dividend/quotient
    logic [WIDTH-1:0]   r_x;
    // r_y holds the raw divisor until PREP, then its magnitude
    logic [WIDTH-1:0]   r_y;
    // one extra bit: a shifted partial remainder can reach 2*|y|-1
    logic [WIDTH:0]     r_rem;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_result;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_div_zero;

    logic               w_accept;
    logic               w_x_neg;
    logic               w_y_neg;
    logic [WIDTH-1:0]   w_x_mag;
    logic [WIDTH-1:0]   w_y_mag;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_q_fin;
    logic [WIDTH-1:0]   w_r_fin;

    assign in_ready     = !flush && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
    assign w_accept     = in_valid && in_ready;
    assign busy         = (r_state != S_IDLE);
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_tag      = r_out_tag;
    assign out_div_zero = r_out_div_zero;

    // Operand magnitudes; the most negative value maps to itself, which is correct read as unsigned
    assign w_x_neg = r_signed && r_x[WIDTH-1];
    assign w_y_neg = r_signed && r_y[WIDTH-1];
    assign w_x_mag = w_x_neg ? (~r_x + 1'b1) : r_x;
    assign w_y_mag = w_y_neg ? (~r_y + 1'b1) : r_y;

    // Final sign correction of quotient and remainder
    assign w_q_fin = r_q_neg ? (~r_x + 1'b1) : r_x;
    assign w_r_fin = r_r_neg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    // UNROLL restoring shift-subtract steps per cycle, MSB of the dividend first
    always_comb begin
        w_rem_nxt = r_rem;
        w_quo_nxt = r_x;
        for (int i = 0; i < UNROLL; i++) begin
            w_rem_nxt = {w_rem_nxt[WIDTH-1:0], w_quo_nxt[WIDTH-1]};
            w_quo_nxt = {w_quo_nxt[WIDTH-2:0], 1'b0};
            if (w_rem_nxt >= {1'b0, r_y}) begin
                w_rem_nxt    = w_rem_nxt - {1'b0, r_y};
                w_quo_nxt[0] = 1'b1;
            end
        end
    end

    // Control FSM and datapath registers; flush overrides everything except reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_signed       <= 1'b0;
            r_op_rem       <= 1'b0;
            r_tag          <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_rem          <= '0;
            r_q_neg        <= 1'b0;
            r_r_neg        <= 1'b0;
            r_cnt          <= '0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_tag      <= '0;
            r_out_div_zero <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            // covers both a fresh start in IDLE and the DONE handoff that retires the old result
            r_signed    <= in_signed;
            r_op_rem    <= in_op_rem;
            r_tag       <= in_tag;
            r_x         <= in_x;
            r_y         <= in_y;
            r_out_valid <= 1'b0;
            r_state     <= S_PREP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_PREP: begin
                    if (r_y == '0) begin
                        r_out_result   <= r_op_rem ? r_x : '1;
                        r_out_div_zero <= 1'b1;
                        r_out_tag      <= r_tag;
                        r_out_valid    <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_x     <= w_x_mag;
                        r_y     <= w_y_mag;
                        r_rem   <= '0;
                        r_q_neg <= w_x_neg ^ w_y_neg;
                        r_r_neg <= w_x_neg;
                        r_cnt   <= CNT_W'(K);
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_x   <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_POST;
                    end
                end
                S_POST: begin
                    r_out_result   <= r_op_rem ? w_r_fin : w_q_fin;
                    r_out_div_zero <= 1'b0;
                    r_out_tag      <= r_tag;
                    r_out_valid    <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomised and directed checks of ex_div_unit against a plain-arithmetic reference.
// Latency: measured per operation from the accept edge.
// Backpressure: exercised via held out_ready, DONE handoff, flush and async reset.
module tb_ex_div_unit;

    localparam int WIDTH  = 32;
    localparam int UNROLL = 1;
    localparam int TAG_W  = 5;
    localparam int K      = WIDTH / UNROLL;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic             in_op_rem;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_div_zero;
    logic             busy;

    int n_vec;
    int n_err;

    logic [WIDTH-1:0] exp_res;
    logic [TAG_W-1:0] exp_tag;
    logic             exp_dz;
    int               exp_lat;

    ex_div_unit #(.WIDTH(WIDTH), .UNROLL(UNROLL), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_op_rem    (in_op_rem),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_div_zero (out_div_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic in 64 bits, truncating division, low WIDTH bits kept
    task automatic ref_div(input bit s, input bit rem, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] res, output logic dz);
        longint xs, ys, q, r;
        if (y == 32'd0) begin
            dz  = 1'b1;
            res = rem ? x : 32'hFFFF_FFFF;
        end else begin
            dz = 1'b0;
            if (s) begin
                xs = longint'($signed(x));
                ys = longint'($signed(y));
            end else begin
                xs = longint'({32'd0, x});
                ys = longint'({32'd0, y});
            end
            q   = xs / ys;
            r   = xs % ys;
            res = rem ? r[31:0] : q[31:0];
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit s, input bit rem, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] tag);
        logic [31:0] r;
        logic        d;
        in_valid  = 1'b1;
        in_signed = s;
        in_op_rem = rem;
        in_x      = x;
        in_y      = y;
        in_tag    = tag;
        ref_div(s, rem, x, y, r, d);
        exp_res = r;
        exp_dz  = d;
        exp_tag = tag;
        exp_lat = d ? 2 : K + 3;
    endtask

    // Inputs after the accept are scrambled to show they are ignored
    task automatic drop_inputs;
        in_valid  = 1'b0;
        in_signed = 1'($urandom);
        in_op_rem = 1'($urandom);
        in_x      = $urandom;
        in_y      = $urandom;
        in_tag    = TAG_W'($urandom);
    endtask

    task automatic start_op(input bit s, input bit rem, input logic [31:0] x, input logic [31:0] y,
                            input logic [TAG_W-1:0] tag);
        int w;
        w = 0;
        set_op(s, rem, x, y, tag);
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) chk("accept_timeout", 64'(w), 64'd0);
        tick();
        drop_inputs();
    endtask

    // lat0 = cycles already elapsed since the accept edge (1 right after it)
    task automatic wait_result(input int lat0);
        int lat;
        lat = lat0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", 64'(out_result), 64'(exp_res));
        chk("tag", 64'(out_tag), 64'(exp_tag));
        chk("div_zero", 64'(out_div_zero), 64'(exp_dz));
    endtask

    task automatic retire;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("retired", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          seen;
        logic [31:0] hold_res;
        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drop_inputs();
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_dz", 64'(out_div_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Directed cases
        start_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd5);           wait_result(1); retire();
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd5);           wait_result(1); retire();
        start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd1);     wait_result(1); retire();
        start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd2);     wait_result(1); retire();
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 5'd3);     wait_result(1); retire();
        start_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd4);     wait_result(1); retire();
        start_op(1'b0, 1'b0, 32'd5, 32'd0, 5'd6);             wait_result(1); retire();
        start_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd7);             wait_result(1); retire();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8); wait_result(1); retire();
        start_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); wait_result(1); retire();

        // Backpressure: held result, then DONE handoff to a new op
        start_op(1'b0, 1'b0, 32'd1000, 32'd33, 5'd10);
        wait_result(1);
        hold_res = out_result;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(out_result), 64'(hold_res));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        set_op(1'b1, 1'b1, 32'hFFFF_FC00, 32'd7, 5'd11);
        out_ready = 1'b1;
        #1;
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        tick();
        out_ready = 1'b0;
        drop_inputs();
        chk("handoff_retired", 64'(out_valid), 64'd0);
        chk("handoff_busy", 64'(busy), 64'd1);
        wait_result(1);
        retire();

        // Flush in ITER cycle 10 alongside a request that must not be accepted
        start_op(1'b0, 1'b0, 32'd12345, 32'd11, 5'd12);
        repeat (10) tick();
        flush = 1'b1;
        set_op(1'b0, 1'b0, 32'd9, 32'd3, 5'd13);
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        drop_inputs();
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        start_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd14);         wait_result(1); retire();

        // Asynchronous reset mid-ITER
        start_op(1'b0, 1'b1, 32'd999, 32'd10, 5'd15);
        repeat (10) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_result", 64'(out_result), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        chk("arst_dz", 64'(out_div_zero), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Randomised regression with random consumer stalls
        for (int n = 0; n < 60; n++) begin
            start_op(1'($urandom), 1'($urandom), pick_operand(), pick_operand(), TAG_W'($urandom));
            wait_result(1);
            repeat ($urandom_range(0, 3)) tick();
            chk("stall_result", 64'(out_result), 64'(exp_res));
            retire();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
